// File: rtl/wb_pkg.sv
// Shared encodings and helpers for the write-back stage.
package wb_pkg;

    // Write-data source select.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_e;

    // Load width; 2'b11 is not named and behaves as a word.
    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } load_size_e;

    // A half is misaligned on an odd address, a word on any non-zero offset.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            LS_BYTE: mis = 1'b0;
            LS_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Byte-lane selection and sign/zero extension of load data.
module load_extract
    import wb_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] data_i,
    input  logic [1:0]   addr_lo_i,
    input  logic [1:0]   size_i,
    input  logic         unsigned_i,
    output logic [N-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend it to the full datapath width.
    always_comb begin
        byte_sel = data_i[7:0];
        unique case (addr_lo_i)
            2'd0: byte_sel = data_i[7:0];
            2'd1: byte_sel = data_i[15:8];
            2'd2: byte_sel = data_i[23:16];
            2'd3: byte_sel = data_i[31:24];
        endcase
        // Halves ignore addr_lo[0]; misalignment is flagged elsewhere.
        half_sel = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];

        result_o = data_i;
        case (size_i)
            LS_BYTE: result_o = {{(N-8){~unsigned_i & byte_sel[7]}}, byte_sel};
            LS_HALF: result_o = {{(N-16){~unsigned_i & half_sel[15]}}, half_sel};
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_reg.sv
// Write-back pipeline register with load alignment and a retire counter.
module wb_stage_reg
    import wb_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned N_REG = 256,
    parameter int unsigned CNT_W = 32,
    localparam int unsigned R    = $clog2(N_REG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [1:0]       wb_sel,
    input  logic [1:0]       load_size,
    input  logic             load_unsigned,
    input  logic [1:0]       addr_lo,
    input  logic [N-1:0]     read_data,
    input  logic [N-1:0]     alu_out,
    input  logic [N-1:0]     link_addr,
    input  logic [N-1:0]     imm,
    input  logic             reg_write,
    input  logic [R-1:0]     write_reg,
    output logic [N-1:0]     write_data_wb,
    output logic             reg_write_wb,
    output logic [R-1:0]     write_reg_wb,
    output logic             valid_wb,
    output logic             misaligned_wb,
    output logic [CNT_W-1:0] retired_cnt
);

    logic             valid_q, valid_d;
    logic [1:0]       wb_sel_q;
    logic [1:0]       load_size_q;
    logic             load_unsigned_q;
    logic [1:0]       addr_lo_q;
    logic [N-1:0]     read_data_q;
    logic [N-1:0]     alu_out_q;
    logic [N-1:0]     link_addr_q;
    logic [N-1:0]     imm_q;
    logic             reg_write_q;
    logic [R-1:0]     write_reg_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     load_data;

    // Flush wins over stall; otherwise a stall holds the slot.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
        end
    end

    // An instruction retires on the edge it leaves WB, so a stalled one counts once.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !stall) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // WB register: payload follows stall only, the slot valid follows flush too.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q         <= 1'b0;
            wb_sel_q        <= WB_ALU;
            load_size_q     <= LS_BYTE;
            load_unsigned_q <= 1'b0;
            addr_lo_q       <= 2'b00;
            read_data_q     <= '0;
            alu_out_q       <= '0;
            link_addr_q     <= '0;
            imm_q           <= '0;
            reg_write_q     <= 1'b0;
            write_reg_q     <= '0;
        end else begin
            valid_q <= valid_d;
            if (!stall) begin
                wb_sel_q        <= wb_sel;
                load_size_q     <= load_size;
                load_unsigned_q <= load_unsigned;
                addr_lo_q       <= addr_lo;
                read_data_q     <= read_data;
                alu_out_q       <= alu_out;
                link_addr_q     <= link_addr;
                imm_q           <= imm;
                reg_write_q     <= reg_write;
                write_reg_q     <= write_reg;
            end
        end
    end

    // Retire counter; wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    load_extract #(
        .N (N)
    ) u_load_extract (
        .data_i     (read_data_q),
        .addr_lo_i  (addr_lo_q),
        .size_i     (load_size_q),
        .unsigned_i (load_unsigned_q),
        .result_o   (load_data)
    );

    // Output mux and write qualification from the registered slot.
    always_comb begin
        write_data_wb = alu_out_q;
        case (wb_sel_q)
            WB_ALU:  write_data_wb = alu_out_q;
            WB_MEM:  write_data_wb = load_data;
            WB_LINK: write_data_wb = link_addr_q;
            WB_IMM:  write_data_wb = imm_q;
            default: write_data_wb = alu_out_q;
        endcase
        misaligned_wb = valid_q && (wb_sel_q == WB_MEM) && is_misaligned(load_size_q, addr_lo_q);
        reg_write_wb  = valid_q && reg_write_q && (write_reg_q != '0) && !misaligned_wb;
    end

    assign write_reg_wb = write_reg_q;
    assign valid_wb     = valid_q;
    assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Self-checking bench for wb_stage_reg (N=32, N_REG=256, CNT_W=4).
module tb_wb_stage_reg;

    localparam int unsigned N  = 32;
    localparam int unsigned R  = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic          in_valid, stall, flush;
    logic [1:0]    wb_sel, load_size, addr_lo;
    logic          load_unsigned, reg_write;
    logic [N-1:0]  read_data, alu_out, link_addr, imm;
    logic [R-1:0]  write_reg;
    logic [N-1:0]  write_data_wb;
    logic          reg_write_wb, valid_wb, misaligned_wb;
    logic [R-1:0]  write_reg_wb;
    logic [CW-1:0] retired_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the WB slot should hold and how many have retired.
    logic         m_valid;
    logic [1:0]   m_sel, m_size, m_addr;
    logic         m_uns, m_rw;
    logic [31:0]  m_rd, m_alu, m_link, m_imm;
    logic [R-1:0] m_wreg;
    int           m_cnt;

    logic [31:0] byte_signed[4]   = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    logic [31:0] byte_unsigned[4] = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};

    wb_stage_reg #(
        .N     (N),
        .N_REG (256),
        .CNT_W (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .wb_sel        (wb_sel),
        .load_size     (load_size),
        .load_unsigned (load_unsigned),
        .addr_lo       (addr_lo),
        .read_data     (read_data),
        .alu_out       (alu_out),
        .link_addr     (link_addr),
        .imm           (imm),
        .reg_write     (reg_write),
        .write_reg     (write_reg),
        .write_data_wb (write_data_wb),
        .reg_write_wb  (reg_write_wb),
        .write_reg_wb  (write_reg_wb),
        .valid_wb      (valid_wb),
        .misaligned_wb (misaligned_wb),
        .retired_cnt   (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected write data, computed arithmetically from the captured fields.
    function automatic logic [31:0] exp_wdata();
        longint unsigned rd;
        longint v;
        rd = longint'(m_rd);
        case (m_sel)
            2'd0: return m_alu;
            2'd2: return m_link;
            2'd3: return m_imm;
            default: begin
                if (m_size == 2'd0) begin
                    v = longint'((rd >> (8 * m_addr)) % 256);
                    if (!m_uns && v >= 128) v = v - 256;
                    return v[31:0];
                end else if (m_size == 2'd1) begin
                    v = longint'((rd >> (16 * (m_addr / 2))) % 65536);
                    if (!m_uns && v >= 32768) v = v - 65536;
                    return v[31:0];
                end
                return m_rd;
            end
        endcase
    endfunction

    function automatic logic exp_mis();
        if (!m_valid || m_sel != 2'd1) return 1'b0;
        if (m_size == 2'd0) return 1'b0;
        if (m_size == 2'd1) return (m_addr % 2) == 1;
        return m_addr != 0;
    endfunction

    task automatic check_all(input string tag);
        logic mis;
        mis = exp_mis();
        chk({tag, ".valid"}, 64'(valid_wb), 64'(m_valid));
        chk({tag, ".mis"}, 64'(misaligned_wb), 64'(mis));
        chk({tag, ".rw"}, 64'(reg_write_wb), 64'(m_valid && m_rw && m_wreg != 0 && !mis));
        chk({tag, ".cnt"}, 64'(retired_cnt), 64'(m_cnt));
        if (m_valid) begin
            chk({tag, ".wdata"}, 64'(write_data_wb), 64'(exp_wdata()));
            chk({tag, ".wreg"}, 64'(write_reg_wb), 64'(m_wreg));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, 64'(valid_wb), 64'd0);
        chk({tag, ".rw"}, 64'(reg_write_wb), 64'd0);
        chk({tag, ".mis"}, 64'(misaligned_wb), 64'd0);
        chk({tag, ".wreg"}, 64'(write_reg_wb), 64'd0);
        chk({tag, ".wdata"}, 64'(write_data_wb), 64'd0);
        chk({tag, ".cnt"}, 64'(retired_cnt), 64'd0);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_sel = 2'd0; m_size = 2'd0; m_addr = 2'd0; m_uns = 1'b0;
        m_rw = 1'b0; m_rd = '0; m_alu = '0; m_link = '0; m_imm = '0; m_wreg = '0;
        m_cnt = 0;
    endtask

    // One clock edge: update the model with the inputs as seen at the edge, then settle.
    task automatic tick();
        @(posedge clk);
        if (m_valid && !stall) m_cnt = (m_cnt + 1) % 16;
        if (flush) m_valid = 1'b0;
        else if (!stall) m_valid = in_valid;
        if (!stall) begin
            m_sel = wb_sel; m_size = load_size; m_addr = addr_lo; m_uns = load_unsigned;
            m_rw = reg_write; m_rd = read_data; m_alu = alu_out; m_link = link_addr;
            m_imm = imm; m_wreg = write_reg;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [1:0] size,
                         input logic uns, input logic [1:0] a, input logic [31:0] rd,
                         input logic [31:0] alu, input logic rw, input logic [R-1:0] wreg);
        in_valid = v; wb_sel = sel; load_size = size; load_unsigned = uns; addr_lo = a;
        read_data = rd; alu_out = alu; link_addr = $urandom; imm = $urandom;
        reg_write = rw; write_reg = wreg;
    endtask

    task automatic drive_random();
        drive(($urandom % 4) != 0, 2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
              $urandom, $urandom, 1'($urandom), (($urandom % 4) == 0) ? '0 : R'($urandom));
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, '0, '0, 1'b0, '0);
        model_reset();
        #2;
        check_zero("por");
        #10;
        reset = 1'b1;

        // A few random ops, then hold a valid instruction and reset mid-stall.
        for (int i = 0; i < 6; i++) begin
            drive_random();
            tick();
            check_all("warm");
        end
        drive(1'b1, 2'd0, 2'd2, 1'b0, 2'd0, '0, 32'hDEAD, 1'b1, 8'd9);
        tick();
        stall = 1'b1;
        tick();
        check_all("prestall");
        #2;
        reset = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        reset = 1'b1;
        stall = 1'b0;

        // First ALU op after reset.
        drive(1'b1, 2'd0, 2'd2, 1'b0, 2'd0, '0, 32'h1234, 1'b1, 8'd5);
        tick();
        chk("alu.wdata", 64'(write_data_wb), 64'h1234);
        chk("alu.rw", 64'(reg_write_wb), 64'd1);
        chk("alu.wreg", 64'(write_reg_wb), 64'd5);
        check_all("alu");
        drive(1'b0, 2'd0, 2'd2, 1'b0, 2'd0, '0, '0, 1'b0, '0);
        tick();
        chk("alu.cnt", 64'(retired_cnt), 64'd1);

        // Byte loads over every lane, signed and unsigned.
        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < 4; a++) begin
                drive(1'b1, 2'd1, 2'd0, 1'(u), 2'(a), 32'h80FF7F01, '0, 1'b1, 8'd3);
                tick();
                chk(u ? "ldbu" : "ldb", 64'(write_data_wb),
                    64'(u ? byte_unsigned[a] : byte_signed[a]));
                check_all("ldb");
            end
        end

        // Misaligned half: flagged, write suppressed, still retires.
        drive(1'b1, 2'd1, 2'd1, 1'b0, 2'd1, 32'h12345678, '0, 1'b1, 8'd7);
        tick();
        chk("mis.flag", 64'(misaligned_wb), 64'd1);
        chk("mis.rw", 64'(reg_write_wb), 64'd0);
        check_all("mis");
        drive(1'b0, 2'd0, 2'd2, 1'b0, 2'd0, '0, '0, 1'b0, '0);
        tick();
        check_all("mis.ret");

        // Three-cycle stall with changing inputs, then release.
        drive(1'b1, 2'd0, 2'd2, 1'b0, 2'd0, '0, 32'hCAFE, 1'b1, 8'd12);
        tick();
        check_all("st0");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            tick();
            check_all("stall");
        end
        stall = 1'b0;
        drive(1'b0, 2'd0, 2'd2, 1'b0, 2'd0, '0, '0, 1'b0, '0);
        tick();
        check_all("strel");

        // Stall and flush together kill the slot.
        drive(1'b1, 2'd2, 2'd2, 1'b0, 2'd0, '0, '0, 1'b1, 8'd4);
        tick();
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("sflush.valid", 64'(valid_wb), 64'd0);
        check_all("sflush");
        stall = 1'b0; flush = 1'b0;

        // x0 write is suppressed.
        drive(1'b1, 2'd0, 2'd2, 1'b0, 2'd0, '0, 32'h55, 1'b1, 8'd0);
        tick();
        chk("x0.rw", 64'(reg_write_wb), 64'd0);
        check_all("x0");

        // Counter wrap: 15 retirements, the 16th returns to zero.
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'd0, 2'd2, 1'b0, 2'd0, '0, 32'(i), 1'b1, 8'd1);
            tick();
        end
        chk("wrap.15", 64'(retired_cnt), 64'd15);
        tick();
        chk("wrap.0", 64'(retired_cnt), 64'd0);
        check_all("wrap");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            stall = ($urandom % 4) == 0;
            flush = ($urandom % 8) == 0;
            tick();
            check_all("rnd");
        end
        stall = 1'b0; flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
